// File: rtl/elevator_car_ctrl.sv
`timescale 1ns/1ps
// Car motion/door controller: SCAN scheduling over the latched request vector, one floor per MOVE_CYCLES, door held DOOR_CYCLES.
// Latency: a request seen in cycle T changes state/outputs in T+1; all outputs are registered and have no comb path from req.
// Backpressure: none; req is a level input sampled only at decision points, clr retires the current floor while the door is open.
module elevator_car_ctrl #(
    parameter int NUM_FLOORS  = 8,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3,
    localparam int FW = (NUM_FLOORS  > 1) ? $clog2(NUM_FLOORS)  : 1,
    localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1,
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [NUM_FLOORS-1:0] clr,
    output logic [FW-1:0]         floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    localparam logic [NUM_FLOORS-1:0] ONE_HOT0  = NUM_FLOORS'(1);
    localparam logic [MW-1:0]         MOVE_LAST = MW'(MOVE_CYCLES - 1);
    localparam logic [DW-1:0]         DOOR_LAST = DW'(DOOR_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [FW-1:0]           floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [MW-1:0]           move_cnt_q, move_cnt_d;
    logic [DW-1:0]           door_cnt_q, door_cnt_d;
    logic [NUM_FLOORS-1:0]   clr_q;
    logic                    moving_q;
    logic                    door_q;

    logic                    here, above, below;
    logic [FW-1:0]           step_floor;
    logic                    step_here, step_ahead;

    // Any pending request strictly above floor f.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] r, input logic [FW-1:0] f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f) && r[i]) a = 1'b1;
        end
        return a;
    endfunction

    // Any pending request strictly below floor f.
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] r, input logic [FW-1:0] f);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f) && r[i]) b = 1'b1;
        end
        return b;
    endfunction

    // Request decode at the current floor and at the floor reached by the step in progress.
    always_comb begin
        here       = req[floor_q];
        above      = any_above(req, floor_q);
        below      = any_below(req, floor_q);
        step_floor = (state_q == S_MOVE_DOWN) ? (floor_q - FW'(1)) : (floor_q + FW'(1));
        step_here  = req[step_floor];
        step_ahead = (state_q == S_MOVE_DOWN) ? any_below(req, step_floor)
                                              : any_above(req, step_floor);
    end

    // SCAN next-state: keep direction while work lies ahead, reverse only from IDLE.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        move_cnt_d = move_cnt_q;
        door_cnt_d = door_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (here) begin
                    state_d    = S_DOOR_OPEN;
                    door_cnt_d = '0;
                end else if (dir_q && above) begin
                    state_d    = S_MOVE_UP;
                    move_cnt_d = '0;
                end else if (below) begin
                    state_d    = S_MOVE_DOWN;
                    dir_d      = 1'b0;
                    move_cnt_d = '0;
                end else if (above) begin
                    state_d    = S_MOVE_UP;
                    dir_d      = 1'b1;
                    move_cnt_d = '0;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (move_cnt_q == MOVE_LAST) begin
                    // Floor only changes here; the stop decision uses req at the new floor.
                    floor_d    = step_floor;
                    move_cnt_d = '0;
                    if (step_here) begin
                        state_d    = S_DOOR_OPEN;
                        door_cnt_d = '0;
                    end else if (!step_ahead) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    move_cnt_d = move_cnt_q + MW'(1);
                end
            end
            S_DOOR_OPEN: begin
                if (door_cnt_q == DOOR_LAST) begin
                    // A request still pending here (re-pressed) keeps the door open another period.
                    door_cnt_d = '0;
                    if (!here) state_d = S_IDLE;
                end else begin
                    door_cnt_d = door_cnt_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered output decode of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            move_cnt_q <= '0;
            door_cnt_q <= '0;
            clr_q      <= '0;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            move_cnt_q <= move_cnt_d;
            door_cnt_q <= door_cnt_d;
            clr_q      <= (state_d == S_DOOR_OPEN) ? (ONE_HOT0 << floor_d) : '0;
            moving_q   <= (state_d == S_MOVE_UP) || (state_d == S_MOVE_DOWN);
            door_q     <= (state_d == S_DOOR_OPEN);
        end
    end

    assign clr       = clr_q;
    assign floor     = floor_q;
    assign dir_up    = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;

endmodule
